mult_div_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS EX stage. It executes MULT, MULTU, DIV and DIVU over a fixed multi-cycle latency and supports MTHI/MTLO writes. It presents the selected HI or LO value on `data_o`, which drives input 4 (`sel_i = 2'b11`) of the 4-input writeback/result multiplexor. The hazard unit stalls the pipeline on `busy_o`.

---
 rtl/mult_div_unit.sv | 176 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Brief    : Iterative MULT/MULTU/DIV/DIVU engine with HI/LO registers.
// Revision : 1.0
// ============================================================================
module mult_div_unit #(
  parameter int NB_DATA = 32
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [NB_DATA-1:0] rs_i,
  input  logic [NB_DATA-1:0] rt_i,
  input  logic               mthi_i,
  input  logic               mtlo_i,
  input  logic [NB_DATA-1:0] wr_data_i,
  input  logic               rd_sel_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [NB_DATA-1:0] hi_o,
  output logic [NB_DATA-1:0] lo_o,
  output logic [NB_DATA-1:0] data_o
);

  localparam int                   c_CNT_W    = $clog2(NB_DATA + 1);
  localparam logic [c_CNT_W-1:0]   c_CNT_INIT = c_CNT_W'(NB_DATA);
  localparam logic [c_CNT_W-1:0]   c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [NB_DATA-1:0]   c_ZERO     = '0;
  localparam logic [NB_DATA-1:0]   c_ONES     = '1;
  localparam logic [2*NB_DATA-1:0] c_ZERO2    = '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_is_div;
  logic                 r_div_zero;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic [NB_DATA-1:0]   r_oper;
  logic [NB_DATA-1:0]   r_rs_orig;
  logic [NB_DATA-1:0]   r_acc_hi;
  logic [NB_DATA-1:0]   r_acc_lo;
  logic [NB_DATA-1:0]   r_hi;
  logic [NB_DATA-1:0]   r_lo;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_signed;
  logic                 w_rs_neg;
  logic                 w_rt_neg;
  logic [NB_DATA-1:0]   w_rs_mag;
  logic [NB_DATA-1:0]   w_rt_mag;
  logic [NB_DATA:0]     w_sum;
  logic [NB_DATA:0]     w_shift;
  logic                 w_fits;
  logic [NB_DATA-1:0]   w_diff;
  logic [2*NB_DATA-1:0] w_prod;
  logic [2*NB_DATA-1:0] w_prod_fix;
  logic [NB_DATA-1:0]   w_quo_fix;
  logic [NB_DATA-1:0]   w_rem_fix;

  // Operand magnitudes; unsigned ops pass straight through
  assign w_signed = ~op_i[0];
  assign w_rs_neg = w_signed & rs_i[NB_DATA-1];
  assign w_rt_neg = w_signed & rt_i[NB_DATA-1];
  assign w_rs_mag = w_rs_neg ? (c_ZERO - rs_i) : rs_i;
  assign w_rt_mag = w_rt_neg ? (c_ZERO - rt_i) : rt_i;

  // Shift-add step: conditional add into the upper half, then shift right
  assign w_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_oper} : {1'b0, c_ZERO});

  // Restoring step: the shifted partial remainder is NB_DATA+1 bits wide; when
  // it fits, the difference is below the divisor and so fits in NB_DATA bits
  assign w_shift = {r_acc_hi, r_acc_lo[NB_DATA-1]};
  assign w_fits  = (w_shift >= {1'b0, r_oper});
  assign w_diff  = w_shift[NB_DATA-1:0] - r_oper;

  assign w_prod     = {r_acc_hi, r_acc_lo};
  assign w_prod_fix = r_neg_q ? (c_ZERO2 - w_prod) : w_prod;
  assign w_quo_fix  = r_neg_q ? (c_ZERO - r_acc_lo) : r_acc_lo;
  assign w_rem_fix  = r_neg_r ? (c_ZERO - r_acc_hi) : r_acc_hi;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_div_zero <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_oper     <= '0;
      r_rs_orig  <= '0;
      r_acc_hi   <= '0;
      r_acc_lo   <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_is_div   <= op_i[1];
            r_div_zero <= (rt_i == c_ZERO);
            r_neg_q    <= w_rs_neg ^ w_rt_neg;
            r_neg_r    <= w_rs_neg;
            r_rs_orig  <= rs_i;
            r_acc_hi   <= c_ZERO;
            r_cnt      <= c_CNT_INIT;
            r_busy     <= 1'b1;
            r_state    <= S_CALC;
            if (op_i[1]) begin
              r_oper   <= w_rt_mag;
              r_acc_lo <= w_rs_mag;
            end else begin
              r_oper   <= w_rs_mag;
              r_acc_lo <= w_rt_mag;
            end
          end else begin
            if (mthi_i) r_hi <= wr_data_i;
            if (mtlo_i) r_lo <= wr_data_i;
          end
        end

        S_CALC: begin
          if (r_is_div) begin
            r_acc_hi <= w_fits ? w_diff : w_shift[NB_DATA-1:0];
            r_acc_lo <= {r_acc_lo[NB_DATA-2:0], w_fits};
          end else begin
            r_acc_hi <= w_sum[NB_DATA:1];
            r_acc_lo <= {w_sum[0], r_acc_lo[NB_DATA-1:1]};
          end
          r_cnt <= r_cnt - c_CNT_ONE;
          if (r_cnt == c_CNT_ONE) r_state <= S_FIX;
        end

        S_FIX: begin
          if (!r_is_div) begin
            r_hi <= w_prod_fix[2*NB_DATA-1:NB_DATA];
            r_lo <= w_prod_fix[NB_DATA-1:0];
          end else if (r_div_zero) begin
            r_hi <= r_rs_orig;
            r_lo <= c_ONES;
          end else begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o = r_busy;
  assign done_o = r_done;
  assign hi_o   = r_hi;
  assign lo_o   = r_lo;
  assign data_o = rd_sel_i ? r_hi : r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Brief    : Randomized self-checking bench for mult_div_unit.
// Revision : 1.0
// ============================================================================
module tb_mult_div_unit;

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] rs_i = '0;
  logic [31:0] rt_i = '0;
  logic        mthi_i = 1'b0;
  logic        mtlo_i = 1'b0;
  logic [31:0] wr_data_i = '0;
  logic        rd_sel_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [31:0] data_o;

  int n_checks = 0;
  int n_pass = 0;

  mult_div_unit #(.NB_DATA(32)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .op_i(op_i),
    .rs_i(rs_i), .rt_i(rt_i), .mthi_i(mthi_i), .mtlo_i(mtlo_i),
    .wr_data_i(wr_data_i), .rd_sel_i(rd_sel_i), .busy_o(busy_o),
    .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o), .data_o(data_o)
  );

  always #5 clock_i = ~clock_i;

  // Reference: MIPS HI/LO semantics computed with 64-bit arithmetic
  function automatic void model(input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] hi,
                                output logic [31:0] lo);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] ua, ub, p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      2'b00: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin p = ua * ub; hi = p[63:32]; lo = p[31:0]; end
      2'b10: begin
        if (b == 32'h0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else begin sq = sa / sb; sr = sa % sb; hi = sr[31:0]; lo = sq[31:0]; end
      end
      default: begin
        if (b == 32'h0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else begin p = ua / ub; hi = a % b; lo = p[31:0]; end
      end
    endcase
  endfunction

  // Launch one op and wait (bounded) for done; lat counts edges after start edge
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output bit busy_ok);
    @(negedge clock_i);
    start_i = 1'b1; op_i = op; rs_i = a; rt_i = b;
    @(posedge clock_i); #1;
    start_i = 1'b0;
    busy_ok = busy_o;
    lat = 0;
    while (!done_o && lat < 60) begin
      @(posedge clock_i); #1;
      lat++;
      if (!done_o && !busy_o) busy_ok = 1'b0;
    end
    if (busy_o) busy_ok = 1'b0;
  endtask

  task automatic test_reset;
    reset_i = 1'b0;
    #12;
    n_checks++; if ({busy_o, done_o} !== 2'b00) $display("FAIL reset_flags: got %b expected 00", {busy_o, done_o}); else n_pass++;
    n_checks++; if (hi_o !== 32'h0) $display("FAIL reset_hi: got %h expected 0", hi_o); else n_pass++;
    n_checks++; if (lo_o !== 32'h0) $display("FAIL reset_lo: got %h expected 0", lo_o); else n_pass++;
    n_checks++; if (data_o !== 32'h0) $display("FAIL reset_data: got %h expected 0", data_o); else n_pass++;
    @(negedge clock_i);
    reset_i = 1'b1;
  endtask

  task automatic test_directed;
    logic [1:0] ops [5] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b10};
    logic [31:0] as [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd5, 32'h8000_0000};
    logic [31:0] bs [5] = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] ehi [5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'h0};
    logic [31:0] elo [5] = '{32'h0000_0001, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
    int lat;
    bit bok;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], as[i], bs[i], lat, bok);
      n_checks++; if (lat !== 33) $display("FAIL dir%0d_latency: got %0d expected 33", i, lat); else n_pass++;
      n_checks++; if (!bok) $display("FAIL dir%0d_busy: got 0 expected busy through edge 32 then low", i); else n_pass++;
      n_checks++; if (hi_o !== ehi[i]) $display("FAIL dir%0d_hi: got %h expected %h", i, hi_o, ehi[i]); else n_pass++;
      n_checks++; if (lo_o !== elo[i]) $display("FAIL dir%0d_lo: got %h expected %h", i, lo_o, elo[i]); else n_pass++;
      @(posedge clock_i); #1;
      n_checks++; if (done_o !== 1'b0) $display("FAIL dir%0d_done_width: got %b expected 0", i, done_o); else n_pass++;
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b, ehi, elo;
    logic [1:0] op;
    int lat;
    bit bok;
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'h0;
        1: b = $urandom_range(1, 20);
        2: b = 32'hFFFF_FFFF - $urandom_range(0, 20);
        default: b = $urandom;
      endcase
      if (i % 5 == 0) a = $urandom_range(0, 1000);
      model(op, a, b, ehi, elo);
      run_op(op, a, b, lat, bok);
      n_checks++;
      if (lat !== 33 || hi_o !== ehi || lo_o !== elo)
        $display("FAIL rand%0d op=%0d a=%h b=%h: got lat=%0d hi=%h lo=%h expected lat=33 hi=%h lo=%h",
                 i, op, a, b, lat, hi_o, lo_o, ehi, elo);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] ehi, elo;
    int lat;
    bit bok;
    run_op(2'b01, 32'd1000, 32'd1000, lat, bok);
    n_checks++; if (done_o !== 1'b1) $display("FAIL b2b_done_first: got %b expected 1", done_o); else n_pass++;
    model(2'b10, 32'hFFFF_FF00, 32'd7, ehi, elo);
    run_op(2'b10, 32'hFFFF_FF00, 32'd7, lat, bok);
    n_checks++; if (lat !== 33) $display("FAIL b2b_latency: got %0d expected 33", lat); else n_pass++;
    n_checks++; if ({hi_o, lo_o} !== {ehi, elo}) $display("FAIL b2b_result: got %h_%h expected %h_%h", hi_o, lo_o, ehi, elo); else n_pass++;
  endtask

  task automatic test_mt;
    logic [31:0] ehi, elo;
    int lat;
    bit bok;
    @(negedge clock_i);
    mthi_i = 1'b1; mtlo_i = 1'b1; wr_data_i = 32'h1234_5678;
    @(posedge clock_i); #1;
    mthi_i = 1'b0; mtlo_i = 1'b0;
    @(negedge clock_i);
    mtlo_i = 1'b1; wr_data_i = 32'h9ABC_DEF0;
    @(posedge clock_i); #1;
    mtlo_i = 1'b0;
    rd_sel_i = 1'b1; #1;
    n_checks++; if (data_o !== 32'h1234_5678) $display("FAIL mt_hi_sel: got %h expected 12345678", data_o); else n_pass++;
    rd_sel_i = 1'b0; #1;
    n_checks++; if (data_o !== 32'h9ABC_DEF0) $display("FAIL mt_lo_sel: got %h expected 9abcdef0", data_o); else n_pass++;
    // start in the same cycle as MT writes: the writes must be dropped
    @(negedge clock_i);
    mthi_i = 1'b1; mtlo_i = 1'b1; wr_data_i = 32'hDEAD_BEEF;
    model(2'b01, 32'd6, 32'd9, ehi, elo);
    run_op(2'b01, 32'd6, 32'd9, lat, bok);
    mthi_i = 1'b0; mtlo_i = 1'b0;
    n_checks++; if ({hi_o, lo_o} !== {ehi, elo}) $display("FAIL mt_start_priority: got %h_%h expected %h_%h", hi_o, lo_o, ehi, elo); else n_pass++;
  endtask

  task automatic test_busy_ignore;
    logic [31:0] ehi, elo;
    int dones, first;
    model(2'b01, 32'hCAFE_0001, 32'h0000_BEEF, ehi, elo);
    @(negedge clock_i);
    start_i = 1'b1; op_i = 2'b01; rs_i = 32'hCAFE_0001; rt_i = 32'h0000_BEEF;
    @(posedge clock_i); #1;
    start_i = 1'b0;
    dones = 0; first = 0;
    for (int e = 1; e <= 45; e++) begin
      if (e == 5) begin
        start_i = 1'b1; op_i = 2'b11; rs_i = 32'd99; rt_i = 32'd3;
        mthi_i = 1'b1; wr_data_i = 32'h5555_AAAA;
      end
      if (e == 8) begin start_i = 1'b0; mthi_i = 1'b0; end
      @(posedge clock_i); #1;
      if (done_o) begin dones++; if (first == 0) first = e; end
    end
    n_checks++; if (dones !== 1) $display("FAIL busy_done_count: got %0d expected 1", dones); else n_pass++;
    n_checks++; if (first !== 33) $display("FAIL busy_latency: got %0d expected 33", first); else n_pass++;
    n_checks++; if ({hi_o, lo_o} !== {ehi, elo}) $display("FAIL busy_result: got %h_%h expected %h_%h", hi_o, lo_o, ehi, elo); else n_pass++;
  endtask

  task automatic test_reset_abort;
    int lat, dones;
    bit bok;
    @(negedge clock_i);
    mthi_i = 1'b1; mtlo_i = 1'b1; wr_data_i = 32'h0F0F_0F0F;
    @(posedge clock_i); #1;
    mthi_i = 1'b0; mtlo_i = 1'b0;
    @(negedge clock_i);
    start_i = 1'b1; op_i = 2'b01; rs_i = 32'd3; rt_i = 32'd4;
    @(posedge clock_i); #1;
    start_i = 1'b0;
    repeat (10) @(posedge clock_i);
    #1 reset_i = 1'b0;
    #1;
    n_checks++; if ({busy_o, hi_o, lo_o} !== 65'h0) $display("FAIL abort_clear: got busy=%b hi=%h lo=%h expected all 0", busy_o, hi_o, lo_o); else n_pass++;
    dones = 0;
    repeat (3) begin @(posedge clock_i); #1; if (done_o) dones++; end
    @(negedge clock_i);
    reset_i = 1'b1;
    repeat (40) begin @(posedge clock_i); #1; if (done_o) dones++; end
    n_checks++; if (dones !== 0) $display("FAIL abort_no_done: got %0d pulses expected 0", dones); else n_pass++;
    run_op(2'b01, 32'd3, 32'd4, lat, bok);
    n_checks++; if ({hi_o, lo_o} !== {32'd0, 32'd12}) $display("FAIL abort_rerun: got %h_%h expected 00000000_0000000c", hi_o, lo_o); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_mt;
    test_busy_ignore;
    test_reset_abort;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
